pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
Parametrised successor to the team's 4-bit ripple-carry adder. Adds two WIDTH-bit operands plus a carry-in through a STAGES-deep carry-save-by-chunk pipeline. Each stage resolves one CHUNK = WIDTH/STAGES slice and hands its carry to the next stage. Sits on datapath arithmetic lanes that need full-width adds at clock rate, with valid/ready flow control on both sides.

Parameters:
WIDTH, 16, operand and sum width in bits; must be ≥1.
STAGES, 4, number of pipeline stages; must divide WIDTH exactly (elaboration error otherwise); STAGES=1 gives a registered ripple adder.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block can accept a beat this cycle
x  input  WIDTH  operand A (unsigned / two's complement, same bits)
y  input  WIDTH  operand B
cin  input  1  carry into bit 0
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result this cycle
z  output  WIDTH  sum x+y+cin modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset (rst=1 at clk edge): all stage valid bits cleared; out_valid=0, z=0, cout=0; in-flight beats discarded, not completed. in_ready is 0 while rst=1.
- Transfer rules: input beat accepted when in_valid & in_ready at a clk edge; result consumed when out_valid & out_ready at a clk edge.
- Global stall: advance = !out_valid | out_ready; in_ready = advance & !rst. When advance=0 every stage holds its state.
- Stage k (k=0..STAGES-1) on advance: latches valid from stage k-1 (stage 0 from in_valid & in_ready). Computes sum bits [(k+1)*CHUNK-1 : k*CHUNK] from the carried operand slices plus the carry from stage k-1 (stage 0 uses cin). Forwards the upper unprocessed operand slices and the already-computed lower sum bits.
- Last stage drives z, cout and out_valid directly from registers.
- Latency: a beat accepted at edge N appears on out_valid/z/cout after edge N+STAGES-1 (visible in the cycle following that edge), when no stall occurs.
- Throughput: one beat per cycle with out_ready held high; bubbles (in_valid=0) propagate as invalid stages and never emit results.
- Stalled output: while out_valid=1 and out_ready=0, z, cout and out_valid hold stable and no input is accepted.
- Simultaneous accept and consume: allowed in the same cycle. Pipeline shifts by one, with no loss or duplication.
- Invalid stages keep their data registers unchanged; only valid bits gate outputs.
- Arithmetic: {cout,z} = x + y + cin exactly (WIDTH+1-bit result). Wrap-around is modulo 2^WIDTH with cout=1.
- Ordering: results emerge strictly in acceptance order.

Optional Feature:
Macro ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit). ovf is the two's-complement signed overflow: carry into MSB XOR carry out of MSB. It is registered alongside z/cout, resets to 0 and holds under stall like z.
- Not defined: port ovf does not exist; no overflow logic is built.

Test Plan (WIDTH=16, STAGES=4 unless stated):
1. Full carry chain: x=0xFFFF, y=0x0001, cin=0, out_ready=1. Required: z=0x0000, cout=1, out_valid in the 4th cycle after accept and for exactly one cycle.
2. Back-to-back stream: 8 consecutive beats x=i, y=0x1000*i, cin=i[0], in_valid=1, out_ready=1. Required: 8 consecutive out_valid cycles, in-order sums, in_ready stays 1.
3. Backpressure: stream 6 beats with out_ready=0 from cycle 3 to cycle 9. Required: in_ready=0 while output is full and stalled; z/cout stable during the stall; all 6 results delivered in order, none dropped or duplicated.
4. Reset mid-flight: accept x=0x1234, y=0x4321, then assert rst for 1 cycle on the next cycle. Required: out_valid=0, z=0, cout=0 after reset, and that beat never emerges. The next beat x=0x0001, y=0x0001 yields z=0x0002.
5. Bubbles plus cin: alternate in_valid 1/0 with x=0x00FF, y=0x0000, cin=1. Required: z=0x0100, cout=0, with results spaced by one idle cycle.
6. ADDER_OVF_EN defined: x=0x7FFF, y=0x0001 gives ovf=1, cout=0. x=0x8000, y=0x8000 gives z=0x0000, ovf=1, cout=1. x=0x0003, y=0xFFFF gives ovf=0. Also rerun scenarios 1–5 with WIDTH=8 and STAGES=1.

Source files
------------

// File: rtl/pipelined_adder.sv
// Chunked pipelined adder: {cout,z} = x + y + cin, one WIDTH/STAGES slice resolved per stage.
// Optional signed-overflow output ovf is built when ADDER_OVF_EN is defined.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH exactly");
  end

  // Stage registers
  logic             v_q [STAGES];
  logic [WIDTH-1:0] x_q [STAGES];
  logic [WIDTH-1:0] y_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];

  // Inputs seen by each stage: stage 0 from the ports, stage k from stage k-1
  logic             p_v [STAGES];
  logic [WIDTH-1:0] p_x [STAGES];
  logic [WIDTH-1:0] p_y [STAGES];
  logic [WIDTH-1:0] p_s [STAGES];
  logic             p_c [STAGES];

  // Stage results
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];

  logic advance;

  assign out_valid = v_q[STAGES-1];
  assign z         = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !rst;

  always_comb begin
    p_v[0] = in_valid && in_ready;
    p_x[0] = x;
    p_y[0] = y;
    p_s[0] = '0;
    p_c[0] = cin;
    for (int k = 1; k < STAGES; k++) begin
      p_v[k] = v_q[k-1];
      p_x[k] = x_q[k-1];
      p_y[k] = y_q[k-1];
      p_s[k] = s_q[k-1];
      p_c[k] = c_q[k-1];
    end
  end

  always_comb begin
    logic [CHUNK:0] t;
    t = '0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, p_x[k][k*CHUNK +: CHUNK]} + {1'b0, p_y[k][k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, p_c[k]};
      s_d[k] = p_s[k];
      s_d[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
      c_d[k] = t[CHUNK];
    end
  end

  // Invalid beats leave the data registers alone; only the valid bits move
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        x_q[k] <= '0;
        y_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= p_v[k];
        if (p_v[k]) begin
          x_q[k] <= p_x[k];
          y_q[k] <= p_y[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
    end
  end

`ifdef ADDER_OVF_EN
  logic msb_carry_in;
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB recovered from its sum bit, compared with the carry out
  assign msb_carry_in = p_x[STAGES-1][WIDTH-1] ^ p_y[STAGES-1][WIDTH-1]
                        ^ s_d[STAGES-1][WIDTH-1];
  assign ovf_d        = msb_carry_in ^ c_d[STAGES-1];
  assign ovf          = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance && p_v[STAGES-1]) begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule
